id_ex_register: RTL and testbench
=================================

# id_ex_register

ID/EX pipeline register of the MIPS core. Captures the decode-stage bundle (main-control ex/mem/wb fields, register-file read data, PC+4, instruction fields, extended immediate) on each clock edge and presents it to the execute stage. It also contains load-use hazard detection, automatic bubble insertion, flush, freeze and a sticky HALT flag.

## Interface
- DATA_WIDTH, 32, datapath and instruction width
- SIZEOP, 6, opcode width
- i_clock  in  1  system clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-low reset
- i_instruccion  in  32  instruction from IF/ID
- i_valid  in  1  IF/ID slot holds a real instruction
- i_ex  in  4  main-control execute field
- i_mem  in  3  main-control memory field; bit 2 = memory read
- i_wb  in  2  main-control writeback field
- i_pc4  in  32  PC+4 of the instruction
- i_rs_data, i_rt_data  in  32 each  register-file read data
- i_flush  in  1  discard incoming instruction, load bubble
- i_stall  in  1  freeze: hold all registered outputs
- o_ex / o_mem / o_wb  out  4 / 3 / 2  registered control fields
- o_pc4, o_rs_data, o_rt_data, o_imm  out  32 each  registered data; o_imm is the extended immediate
- o_opcode, o_funct  out  6 each  instruction [31:26], [5:0]
- o_rs, o_rt, o_rd, o_shamt  out  5 each  instruction [25:21], [20:16], [15:11], [10:6]
- o_valid  out  1  execute-stage slot holds a real instruction
- o_halt  out  1  sticky: a HALT has entered execute
- o_stall_req  out  1  combinational load-use hazard; upstream holds PC and IF/ID while high

## Operation
- **Bubble** = all registered outputs zero, o_valid=0.
- **Update priority per edge:**
  1. !i_reset: bubble; o_halt=0.
  2. i_flush: bubble.
  3. i_stall: hold everything.
  4. o_stall_req: bubble. The instruction in IF/ID is not consumed.
  5. o_halt already 1: bubble.
  6. Otherwise load the inputs: o_valid=i_valid.
- **Loaded values when i_valid=0:** control, data and field outputs are loaded as zero. Never propagate garbage as a valid op.
- **Immediate extension:** opcodes ANDI 001100, ORI 001101, XORI 001110 zero-extend [15:0]. All other opcodes sign-extend [15:0].
- **HALT:** loading a valid instruction with opcode 111111 sets o_halt on the same edge. o_halt stays 1 until reset.
- **o_stall_req** = o_valid & o_mem[2] & (o_rt≠0) & i_valid & (o_rt==i_instruccion[25:21] | (o_rt==i_instruccion[20:16] & opcode∈{000000, 101011, 000100})).
  - Evaluated from registered state and current inputs.
  - Forced 0 while i_stall or i_flush is high.
- **Control fields:** carried opaquely, bit-exact. Undefined bits from main control may pass through on valid instructions; bubbles are always all-zero.

## Timing
- Latency: one cycle, input to registered output.
- Reset is synchronous. Mid-operation reset takes effect at the next edge regardless of i_flush/i_stall, and clears o_halt.
- Load-use: exactly one bubble per hazard. The cycle after the bubble, the hazard condition is false (o_valid=0), so the held instruction loads.
- Simultaneous i_flush and o_stall_req: flush wins; a single bubble is inserted.
- Simultaneous i_stall and hazard: hold; o_stall_req reads 0.
- HALT followed by further instructions: every later edge loads a bubble. o_valid=0 from the cycle after HALT leaves this stage.
- Outputs other than o_stall_req change only on a clock edge.

## Test plan
- **Reset then load:** reset low 2 cycles → all outputs 0. Then apply i_instruccion=0x012A4020 (add $8,$9,$10), i_ex=1010, i_wb=11, i_valid=1 → next edge: o_rs=9, o_rt=10, o_rd=8, o_funct=0x20, o_valid=1, o_stall_req=0.
- **Load-use:** load lw $9,4($1) (0x8C290004, i_mem=100). Next input add $8,$9,$10 → o_stall_req=1 in that cycle; next edge loads a bubble (o_valid=0, o_mem=000); the edge after loads add.
- **Immediate extension:** ori imm 0xFFFF → o_imm=0x0000FFFF; addi imm 0xFFFF → o_imm=0xFFFFFFFF.
- **Flush/stall precedence:**
  - i_stall=1 for 3 cycles with changing inputs → outputs constant.
  - i_flush=1 together with a hazard → one bubble; next edge loads the held instruction normally.
- **HALT:** load 0xFC000000 (valid) → o_halt=1 next edge. Subsequent valid add inputs → o_valid=0. Reset low → o_halt=0.
- **$zero / invalid:** lw to $0 followed by a use of $0 → o_stall_req=0. i_valid=0 with nonzero inputs → bubble loaded.

Source files
------------

// File: rtl/id_ex_register.sv
// ID/EX pipeline register: captures the decode bundle, extends the immediate,
// detects load-use hazards, inserts bubbles on flush/hazard/halt and keeps a
// sticky HALT flag until reset.
module id_ex_register #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SIZEOP     = 6
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_instruccion,
  input  logic                  i_valid,
  input  logic [3:0]            i_ex,
  input  logic [2:0]            i_mem,
  input  logic [1:0]            i_wb,
  input  logic [DATA_WIDTH-1:0] i_pc4,
  input  logic [DATA_WIDTH-1:0] i_rs_data,
  input  logic [DATA_WIDTH-1:0] i_rt_data,
  input  logic                  i_flush,
  input  logic                  i_stall,
  output logic [3:0]            o_ex,
  output logic [2:0]            o_mem,
  output logic [1:0]            o_wb,
  output logic [DATA_WIDTH-1:0] o_pc4,
  output logic [DATA_WIDTH-1:0] o_rs_data,
  output logic [DATA_WIDTH-1:0] o_rt_data,
  output logic [DATA_WIDTH-1:0] o_imm,
  output logic [SIZEOP-1:0]     o_opcode,
  output logic [5:0]            o_funct,
  output logic [4:0]            o_rs,
  output logic [4:0]            o_rt,
  output logic [4:0]            o_rd,
  output logic [4:0]            o_shamt,
  output logic                  o_valid,
  output logic                  o_halt,
  output logic                  o_stall_req
);

  localparam logic [SIZEOP-1:0] OP_RTYPE = 6'b000000;
  localparam logic [SIZEOP-1:0] OP_SW    = 6'b101011;
  localparam logic [SIZEOP-1:0] OP_BEQ   = 6'b000100;
  localparam logic [SIZEOP-1:0] OP_ANDI  = 6'b001100;
  localparam logic [SIZEOP-1:0] OP_ORI   = 6'b001101;
  localparam logic [SIZEOP-1:0] OP_XORI  = 6'b001110;
  localparam logic [SIZEOP-1:0] OP_HALT  = 6'b111111;

  typedef struct packed {
    logic [3:0]            ex;
    logic [2:0]            mem;
    logic [1:0]            wb;
    logic [DATA_WIDTH-1:0] pc4;
    logic [DATA_WIDTH-1:0] rs_data;
    logic [DATA_WIDTH-1:0] rt_data;
    logic [DATA_WIDTH-1:0] imm;
    logic [SIZEOP-1:0]     opcode;
    logic [5:0]            funct;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic [4:0]            shamt;
    logic                  valid;
  } stage_t;

  stage_t stage_q;
  stage_t load_val;
  logic   halt_q;

  logic [SIZEOP-1:0] in_opcode;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [15:0]       in_imm16;
  logic              in_uses_rt;
  logic              zero_ext;

  assign in_opcode  = i_instruccion[DATA_WIDTH-1 -: SIZEOP];
  assign in_rs      = i_instruccion[25:21];
  assign in_rt      = i_instruccion[20:16];
  assign in_imm16   = i_instruccion[15:0];
  assign in_uses_rt = (in_opcode == OP_RTYPE) || (in_opcode == OP_SW) || (in_opcode == OP_BEQ);
  assign zero_ext   = (in_opcode == OP_ANDI) || (in_opcode == OP_ORI) || (in_opcode == OP_XORI);

  // Load-use hazard against the load currently in execute; suppressed under stall/flush
  always_comb begin
    o_stall_req = 1'b0;
    if (!i_stall && !i_flush && stage_q.valid && stage_q.mem[2] &&
        (stage_q.rt != 5'd0) && i_valid) begin
      o_stall_req = (stage_q.rt == in_rs) || ((stage_q.rt == in_rt) && in_uses_rt);
    end
  end

  // Candidate bundle to load; an invalid slot loads as an all-zero bubble
  always_comb begin
    load_val = '0;
    if (i_valid) begin
      load_val.ex      = i_ex;
      load_val.mem     = i_mem;
      load_val.wb      = i_wb;
      load_val.pc4     = i_pc4;
      load_val.rs_data = i_rs_data;
      load_val.rt_data = i_rt_data;
      load_val.imm     = zero_ext ? {{(DATA_WIDTH-16){1'b0}}, in_imm16}
                                  : {{(DATA_WIDTH-16){in_imm16[15]}}, in_imm16};
      load_val.opcode  = in_opcode;
      load_val.funct   = i_instruccion[5:0];
      load_val.rs      = in_rs;
      load_val.rt      = in_rt;
      load_val.rd      = i_instruccion[15:11];
      load_val.shamt   = i_instruccion[10:6];
      load_val.valid   = 1'b1;
    end
  end

  // Pipeline register update: reset > flush > stall > hazard > halted > load
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      stage_q <= '0;
      halt_q  <= 1'b0;
    end else if (i_flush) begin
      stage_q <= '0;
    end else if (i_stall) begin
      stage_q <= stage_q;
    end else if (o_stall_req || halt_q) begin
      stage_q <= '0;
    end else begin
      stage_q <= load_val;
      if (load_val.valid && (load_val.opcode == OP_HALT)) begin
        halt_q <= 1'b1;
      end
    end
  end

  assign o_ex      = stage_q.ex;
  assign o_mem     = stage_q.mem;
  assign o_wb      = stage_q.wb;
  assign o_pc4     = stage_q.pc4;
  assign o_rs_data = stage_q.rs_data;
  assign o_rt_data = stage_q.rt_data;
  assign o_imm     = stage_q.imm;
  assign o_opcode  = stage_q.opcode;
  assign o_funct   = stage_q.funct;
  assign o_rs      = stage_q.rs;
  assign o_rt      = stage_q.rt;
  assign o_rd      = stage_q.rd;
  assign o_shamt   = stage_q.shamt;
  assign o_valid   = stage_q.valid;
  assign o_halt    = halt_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Directed bench for id_ex_register with hand-computed expectations.
module tb_id_ex_register;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [31:0] i_instruccion;
  logic        i_valid;
  logic [3:0]  i_ex;
  logic [2:0]  i_mem;
  logic [1:0]  i_wb;
  logic [31:0] i_pc4;
  logic [31:0] i_rs_data;
  logic [31:0] i_rt_data;
  logic        i_flush;
  logic        i_stall;
  logic [3:0]  o_ex;
  logic [2:0]  o_mem;
  logic [1:0]  o_wb;
  logic [31:0] o_pc4;
  logic [31:0] o_rs_data;
  logic [31:0] o_rt_data;
  logic [31:0] o_imm;
  logic [5:0]  o_opcode;
  logic [5:0]  o_funct;
  logic [4:0]  o_rs;
  logic [4:0]  o_rt;
  logic [4:0]  o_rd;
  logic [4:0]  o_shamt;
  logic        o_valid;
  logic        o_halt;
  logic        o_stall_req;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  id_ex_register #(.DATA_WIDTH(32), .SIZEOP(6)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_instruccion(i_instruccion),
    .i_valid(i_valid), .i_ex(i_ex), .i_mem(i_mem), .i_wb(i_wb),
    .i_pc4(i_pc4), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
    .i_flush(i_flush), .i_stall(i_stall),
    .o_ex(o_ex), .o_mem(o_mem), .o_wb(o_wb), .o_pc4(o_pc4),
    .o_rs_data(o_rs_data), .o_rt_data(o_rt_data), .o_imm(o_imm),
    .o_opcode(o_opcode), .o_funct(o_funct), .o_rs(o_rs), .o_rt(o_rt),
    .o_rd(o_rd), .o_shamt(o_shamt), .o_valid(o_valid), .o_halt(o_halt),
    .o_stall_req(o_stall_req)
  );

  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic valid, input logic [3:0] ex,
                       input logic [2:0] mem, input logic [1:0] wb, input logic [31:0] pc4);
    i_instruccion = instr;
    i_valid       = valid;
    i_ex          = ex;
    i_mem         = mem;
    i_wb          = wb;
    i_pc4         = pc4;
    i_rs_data     = pc4 ^ 32'h1111_1111;
    i_rt_data     = pc4 ^ 32'h2222_2222;
    #1;
  endtask

  localparam logic [31:0] ADD_8_9_10 = 32'h012A_4020;
  localparam logic [31:0] LW_9_1     = 32'h8C29_0004;
  localparam logic [31:0] LW_0_1     = 32'h8C20_0004;
  localparam logic [31:0] ADD_8_0_0  = 32'h0000_4020;
  localparam logic [31:0] ADDI_9_1   = 32'h2029_0005;
  localparam logic [31:0] HALT_INS   = 32'hFC00_0000;

  initial begin
    i_reset = 1'b0;
    i_flush = 1'b0;
    i_stall = 1'b0;
    drive(ADD_8_9_10, 1'b1, 4'b1111, 3'b111, 2'b11, 32'h55);
    step();
    step();
    check("rst_valid", o_valid, 0);
    check("rst_halt", o_halt, 0);
    check("rst_ex", o_ex, 0);
    check("rst_pc4", o_pc4, 0);
    check("rst_imm", o_imm, 0);
    check("rst_stall_req", o_stall_req, 0);

    // Basic load of add $8,$9,$10
    i_reset = 1'b1;
    drive(ADD_8_9_10, 1'b1, 4'b1010, 3'b000, 2'b11, 32'h100);
    step();
    check("add_rs", o_rs, 9);
    check("add_rt", o_rt, 10);
    check("add_rd", o_rd, 8);
    check("add_funct", o_funct, 32'h20);
    check("add_shamt", o_shamt, 0);
    check("add_opcode", o_opcode, 0);
    check("add_valid", o_valid, 1);
    check("add_ex", o_ex, 4'b1010);
    check("add_wb", o_wb, 2'b11);
    check("add_pc4", o_pc4, 32'h100);
    check("add_rs_data", o_rs_data, 32'h1111_1011);
    check("add_rt_data", o_rt_data, 32'h2222_2322);
    check("add_imm", o_imm, 32'h0000_4020);
    check("add_stall_req", o_stall_req, 0);

    // Load-use on rs
    drive(LW_9_1, 1'b1, 4'b0001, 3'b100, 2'b10, 32'h104);
    step();
    check("lw_rt", o_rt, 9);
    check("lw_mem", o_mem, 3'b100);
    check("lw_imm", o_imm, 4);
    drive(ADD_8_9_10, 1'b1, 4'b1010, 3'b000, 2'b11, 32'h108);
    check("lu_stall_req", o_stall_req, 1);
    step();
    check("lu_bubble_valid", o_valid, 0);
    check("lu_bubble_mem", o_mem, 0);
    check("lu_bubble_rd", o_rd, 0);
    check("lu_after_bubble_req", o_stall_req, 0);
    step();
    check("lu_held_valid", o_valid, 1);
    check("lu_held_rd", o_rd, 8);
    check("lu_held_pc4", o_pc4, 32'h108);

    // addi reads only rs: rt match must not stall
    drive(LW_9_1, 1'b1, 4'b0001, 3'b100, 2'b10, 32'h10C);
    step();
    drive(ADDI_9_1, 1'b1, 4'b0001, 3'b000, 2'b10, 32'h110);
    check("addi_rt_no_hazard", o_stall_req, 0);
    // beq uses rt: rt match stalls
    drive(32'h1029_0003, 1'b1, 4'b0000, 3'b000, 2'b00, 32'h110);
    check("beq_rt_hazard", o_stall_req, 1);
    drive(ADDI_9_1, 1'b1, 4'b0001, 3'b000, 2'b10, 32'h110);
    step();
    check("addi_loaded", o_pc4, 32'h110);
    check("addi_imm", o_imm, 5);

    // Immediate extension
    drive(32'h3422_FFFF, 1'b1, 4'b0, 3'b0, 2'b10, 32'h200);
    step();
    check("ori_imm", o_imm, 32'h0000_FFFF);
    drive(32'h2022_FFFF, 1'b1, 4'b0, 3'b0, 2'b10, 32'h204);
    step();
    check("addi_imm_neg", o_imm, 32'hFFFF_FFFF);
    drive(32'h3022_8000, 1'b1, 4'b0, 3'b0, 2'b10, 32'h208);
    step();
    check("andi_imm", o_imm, 32'h0000_8000);
    drive(32'h3822_FFFF, 1'b1, 4'b0, 3'b0, 2'b10, 32'h20C);
    step();
    check("xori_imm", o_imm, 32'h0000_FFFF);
    drive(32'h2822_8000, 1'b1, 4'b0, 3'b0, 2'b10, 32'h210);
    step();
    check("slti_imm", o_imm, 32'hFFFF_8000);

    // Stall with a pending hazard: hold, request reads 0
    drive(LW_9_1, 1'b1, 4'b0001, 3'b100, 2'b10, 32'h300);
    step();
    i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(ADD_8_9_10, 1'b1, 4'b1010, 3'b000, 2'b11, 32'h400 + 32'(i));
      check("stall_req_masked", o_stall_req, 0);
      step();
      check("stall_hold_pc4", o_pc4, 32'h300);
      check("stall_hold_op", o_opcode, 6'h23);
      check("stall_hold_valid", o_valid, 1);
    end
    i_stall = 1'b0;
    #1;
    check("unstall_hazard", o_stall_req, 1);
    i_flush = 1'b1;
    #1;
    check("flush_masks_req", o_stall_req, 0);
    step();
    check("flush_bubble_valid", o_valid, 0);
    check("flush_bubble_pc4", o_pc4, 0);
    i_flush = 1'b0;
    step();
    check("post_flush_load", o_valid, 1);
    check("post_flush_rd", o_rd, 8);

    // HALT
    drive(HALT_INS, 1'b1, 4'b0, 3'b0, 2'b00, 32'h500);
    step();
    check("halt_set", o_halt, 1);
    check("halt_valid", o_valid, 1);
    check("halt_opcode", o_opcode, 6'h3F);
    drive(ADD_8_9_10, 1'b1, 4'b1010, 3'b000, 2'b11, 32'h504);
    step();
    check("halt_bubble1", o_valid, 0);
    check("halt_sticky", o_halt, 1);
    step();
    check("halt_bubble2", o_valid, 0);
    i_reset = 1'b0;
    i_stall = 1'b1;
    i_flush = 1'b1;
    step();
    check("halt_reset_clear", o_halt, 0);
    i_reset = 1'b1;
    i_stall = 1'b0;
    i_flush = 1'b0;

    // $zero destination never stalls
    drive(LW_0_1, 1'b1, 4'b0001, 3'b100, 2'b10, 32'h600);
    step();
    drive(ADD_8_0_0, 1'b1, 4'b1010, 3'b000, 2'b11, 32'h604);
    check("zero_no_hazard", o_stall_req, 0);
    step();
    check("zero_use_loaded", o_rd, 8);

    // Invalid slot with nonzero inputs loads a bubble
    drive(ADD_8_9_10, 1'b0, 4'b1111, 3'b111, 2'b11, 32'hDEAD);
    step();
    check("inv_valid", o_valid, 0);
    check("inv_ex", o_ex, 0);
    check("inv_mem", o_mem, 0);
    check("inv_wb", o_wb, 0);
    check("inv_pc4", o_pc4, 0);
    check("inv_rs", o_rs, 0);
    check("inv_imm", o_imm, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
